// File: rtl/fb_scanout_if.sv
// Framebuffer read port and pixel stream between the scan-out reader,
// the framebuffer memory and the VGA controller.
interface fb_scanout_if #(
  parameter int ADDR_W = 19
);
  logic              fb_rd_en;
  logic [ADDR_W-1:0] fb_rd_addr;
  logic [1:0]        fb_rd_data;
  logic              pix_ready;
  logic              pix_valid;
  logic [9:0]        pru_red;
  logic [9:0]        pru_green;
  logic [9:0]        pru_blue;
  logic              pix_sof;
  logic              pix_eol;
  logic              frame_done;

  modport master (
    output fb_rd_en, fb_rd_addr, pix_valid, pru_red, pru_green, pru_blue,
           pix_sof, pix_eol, frame_done,
    input  fb_rd_data, pix_ready
  );

  modport slave (
    input  fb_rd_en, fb_rd_addr, pix_valid, pru_red, pru_green, pru_blue,
           pix_sof, pix_eol, frame_done,
    output fb_rd_data, pix_ready
  );
endinterface

// File: rtl/fb_scanout.sv
// Framebuffer scan-out: walks the 2-bit colour-index framebuffer in raster
// order, prefetches indices into a small FIFO and presents palette-mapped
// 10-bit RGB pixels over a valid/ready handshake.
module fb_scanout #(
  parameter int H_PIXELS   = 640,
  parameter int V_PIXELS   = 480,
  parameter int ADDR_W     = 19,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic         color_load,
  input  logic [1:0]   color_idx,
  input  logic [9:0]   load_red,
  input  logic [9:0]   load_green,
  input  logic [9:0]   load_blue,
  fb_scanout_if.master bus
);
  localparam int COL_W  = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int ROW_W  = (V_PIXELS > 1) ? $clog2(V_PIXELS) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int SUM_W  = CNT_W + 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_PIXELS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_PIXELS - 1);
  localparam logic [SUM_W-1:0] DEPTH_C  = SUM_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  typedef struct packed {
    logic [1:0] idx;
    logic       sof;
    logic       eol;
    logic       last;
  } entry_t;

  state_t            state;
  logic              rd_en_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic              pend;
  logic              pend_sof;
  logic              pend_eol;
  logic              pend_last;
  logic              frame_done_q;

  entry_t            fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  entry_t            head;
  logic              fifo_valid;
  logic              push;
  logic              pop;
  logic              credit_ok;
  logic              col_last;
  logic              row_last;

  logic [9:0]        pal_red   [4];
  logic [9:0]        pal_green [4];
  logic [9:0]        pal_blue  [4];

  assign head       = fifo_mem[rd_ptr];
  assign fifo_valid = (count != '0);
  assign push       = pend;
  assign pop        = fifo_valid && bus.pix_ready;
  assign count_next = count + CNT_W'(push) - CNT_W'(pop);
  // Next-cycle credit: occupancy after this edge plus the read now in flight.
  assign credit_ok  = ({1'b0, count_next} + SUM_W'(rd_en_q)) < DEPTH_C;
  assign col_last   = (col == COL_LAST);
  assign row_last   = (row == ROW_LAST);

  assign bus.fb_rd_en   = rd_en_q;
  assign bus.fb_rd_addr = rd_addr_q;
  assign bus.pix_valid  = fifo_valid;
  assign bus.frame_done = frame_done_q;

  // Head pixel colour and tags, forced to zero when nothing is presented.
  always_comb begin
    bus.pru_red   = '0;
    bus.pru_green = '0;
    bus.pru_blue  = '0;
    bus.pix_sof   = 1'b0;
    bus.pix_eol   = 1'b0;
    if (fifo_valid) begin
      bus.pru_red   = pal_red[head.idx];
      bus.pru_green = pal_green[head.idx];
      bus.pru_blue  = pal_blue[head.idx];
      bus.pix_sof   = head.sof;
      bus.pix_eol   = head.eol;
    end
  end

  // Prefetch FIFO storage: returning read data joins its issue-time tags.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{idx: bus.fb_rd_data, sof: pend_sof,
                            eol: pend_eol, last: pend_last};
    end
  end

  // Palette registers; a write only affects pixels presented afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pal_red[0]   <= '0;  pal_green[0] <= '0;  pal_blue[0] <= '0;
      pal_red[1]   <= '1;  pal_green[1] <= '0;  pal_blue[1] <= '0;
      pal_red[2]   <= '0;  pal_green[2] <= '1;  pal_blue[2] <= '0;
      pal_red[3]   <= '0;  pal_green[3] <= '0;  pal_blue[3] <= '1;
    end else if (color_load) begin
      pal_red[color_idx]   <= load_red;
      pal_green[color_idx] <= load_green;
      pal_blue[color_idx]  <= load_blue;
    end
  end

  // Scan FSM: read issue, raster counters, FIFO pointers and frame pulse.
  // Leaving RUN clears everything on the entry edge so pix_valid is already
  // low during the FLUSH cycle; the read issued in the last RUN cycle is
  // dropped by clearing pend, and FLUSH repeats the clear before IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      col          <= '0;
      row          <= '0;
      pend         <= 1'b0;
      pend_sof     <= 1'b0;
      pend_eol     <= 1'b0;
      pend_last    <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= pop && head.last;
      unique case (state)
        IDLE: begin
          rd_en_q <= enable;
          if (enable) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (enable) begin
            pend    <= rd_en_q;
            count   <= count_next;
            rd_en_q <= credit_ok;
            if (push) begin
              wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
              rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (rd_en_q) begin
              pend_sof  <= (row == '0) && (col == '0);
              pend_eol  <= col_last;
              pend_last <= col_last && row_last;
              if (col_last) begin
                col <= '0;
                if (row_last) begin
                  row       <= '0;
                  rd_addr_q <= '0;
                end else begin
                  row       <= row + ROW_W'(1);
                  rd_addr_q <= rd_addr_q + ADDR_W'(1);
                end
              end else begin
                col       <= col + COL_W'(1);
                rd_addr_q <= rd_addr_q + ADDR_W'(1);
              end
            end
          end else begin
            state     <= FLUSH;
            rd_en_q   <= 1'b0;
            pend      <= 1'b0;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            col       <= '0;
            row       <= '0;
            rd_addr_q <= '0;
          end
        end
        FLUSH: begin
          state     <= IDLE;
          rd_en_q   <= 1'b0;
          pend      <= 1'b0;
          count     <= '0;
          wr_ptr    <= '0;
          rd_ptr    <= '0;
          col       <= '0;
          row       <= '0;
          rd_addr_q <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/fb_scanout.md
Name: fb_scanout

Overview:
- Display-side reader of the 2-bit colour-index framebuffer that the pixel rendering unit writes.
- Walks the framebuffer in raster order through a synchronous-read port (1-cycle latency) and prefetches indices into a small FIFO.
- Maps each index through a loadable 4-entry RGB palette and presents 10-bit R/G/B pixels to the VGA controller over a valid/ready handshake.

Parameters:
- H_PIXELS, 640, pixels per line
- V_PIXELS, 480, lines per frame
- ADDR_W, 19, framebuffer address width; must satisfy 2^ADDR_W >= H_PIXELS*V_PIXELS
- FIFO_DEPTH, 4, prefetch FIFO entries; power of two, >= 2

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  scan-out enable; level-sensitive
- fb_rd_en  out  1  framebuffer read strobe
- fb_rd_addr  out  ADDR_W  framebuffer read address, row*H_PIXELS+col
- fb_rd_data  in  2  colour index; valid the cycle after fb_rd_en
- color_load  in  1  palette write strobe
- color_idx  in  2  palette entry to write
- load_red / load_green / load_blue  in  10 each  palette write data
- pix_ready  in  1  VGA controller accepts the current pixel (VGA_Read)
- pix_valid  out  1  head pixel present
- pru_red / pru_green / pru_blue  out  10 each  head pixel colour
- pix_sof  out  1  head pixel is row 0, col 0
- pix_eol  out  1  head pixel is col H_PIXELS-1
- frame_done  out  1  one-cycle pulse when the last pixel of a frame is accepted

Behaviour:
- Reset (async assert, sync deassert at the clk edge):
  - fb_rd_en=0, fb_rd_addr=0, pix_valid=0, pix_sof=0, pix_eol=0, frame_done=0.
  - FIFO empty; fetch row/col counters = 0; in-flight count = 0.
  - Palette: idx0=(0,0,0), idx1=(3FF,0,0), idx2=(0,3FF,0), idx3=(0,0,3FF).
- FSM states:
  - IDLE:
    - No reads issued. FIFO held empty, counters held at 0.
    - Move to RUN when enable=1.
  - RUN:
    - Issue fb_rd_en=1 in any cycle where FIFO occupancy + in-flight < FIFO_DEPTH. Back-to-back reads are allowed, one per cycle.
    - fb_rd_addr = fetch_row*H_PIXELS + fetch_col. Maintain it incrementally (+1 per read); no multiplier.
    - On each read, advance col. At col=H_PIXELS-1, col wraps to 0 and row increments.
    - At row=V_PIXELS-1, col=H_PIXELS-1, both wrap to 0 and the address wraps to 0. Scan-out is continuous across frames.
    - Data returning the next cycle is pushed into the FIFO together with sof/eol tags computed at issue time.
  - FLUSH (entered from RUN when enable=0):
    - One cycle: discard FIFO contents and any in-flight read; reset counters and address to 0.
    - pix_valid=0 from the FLUSH cycle onward. Then go to IDLE.
    - Re-enabling always restarts at pixel 0 with pix_sof=1.
- Output:
  - pix_valid = FIFO not empty.
  - pru_red/green/blue = palette[head index], combinational from the head entry and the palette registers.
  - Outputs are 0 when pix_valid=0.
  - A pixel is consumed on a cycle with pix_valid & pix_ready. pix_ready with pix_valid=0 is ignored (underflow) and does not advance anything.
- frame_done is registered: it pulses the cycle after the accepted pixel carrying tag row=V_PIXELS-1 and eol=1.
- Simultaneous FIFO push and pop in the same cycle is legal; occupancy is unchanged.
- The FIFO never overflows: the fetch credit check includes in-flight reads.
- Palette:
  - A color_load write is registered; pixels on the cycle after the write use the new value.
  - A write on the same cycle as a pop does not affect the pixel popped on that cycle.
- Sustained throughput: one pixel per cycle with pix_ready held high. First pix_valid occurs 2 cycles after entering RUN.

Test Plan:
- H_PIXELS=4, V_PIXELS=3, FB preloaded with idx = addr%4. Assert enable, pix_ready=1.
  - Expect 12 pixels in order with colours idx0..3 defaults.
  - pix_sof on pixel 0; pix_eol on pixels 3, 7, 11; frame_done pulse after pixel 11.
  - Pixel 12 is addr 0 with sof=1.
- Backpressure: pix_ready toggles 1,0,0,1 repeating.
  - No pixel dropped or duplicated.
  - fb_rd_en stalls once occupancy+in-flight=4.
  - fb_rd_addr never exceeds 11.
- Palette load: color_load idx1=(155,2AA,0FF) mid-frame.
  - Every idx1 pixel accepted after the write cycle shows (155,2AA,0FF); earlier ones show (3FF,0,0).
- enable drops after 5 pixels, then re-asserts after 3 cycles.
  - pix_valid=0 during the gap.
  - First read after re-enable is addr 0; first pixel has pix_sof=1.
- rst_n asserted mid-frame with the FIFO full.
  - All outputs are 0 immediately (asynchronously).
  - After release, palette idx1 reads back (3FF,0,0) and scan-out restarts at addr 0.
- pix_ready=1 while in IDLE.
  - No pops occur, frame_done stays 0, and no fb_rd_en is issued.
